// File: rtl/bus_2m5s.sv
// Shared bus: 2 masters, 5 slaves, registered two-state arbiter, address decoder and read mux.
// Optional macro BUS_RD_PIPE_EN registers the select used by the read mux (1-cycle read latency).
module bus_2m5s #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    input  logic [DATA_W-1:0] s2_dout,
    input  logic [DATA_W-1:0] s3_dout,
    input  logic [DATA_W-1:0] s4_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,
    output logic              s0_sel,
    output logic              s1_sel,
    output logic              s2_sel,
    output logic              s3_sel,
    output logic              s4_sel,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din
);

    typedef enum logic {
        M0_GNT = 1'b0,
        M1_GNT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_m0_grant;
    logic        r_m1_grant;
    logic [4:0]  w_sel;
    logic [4:0]  w_rd_sel;

    // Arbiter: m0 is never preempted; m1 holds the bus only while it keeps requesting.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state    <= M0_GNT;
            r_m0_grant <= 1'b1;
            r_m1_grant <= 1'b0;
        end else begin
            case (r_state)
                M0_GNT: begin
                    if (!m0_req && m1_req) begin
                        r_state    <= M1_GNT;
                        r_m0_grant <= 1'b0;
                        r_m1_grant <= 1'b1;
                    end else begin
                        r_state    <= M0_GNT;
                        r_m0_grant <= 1'b1;
                        r_m1_grant <= 1'b0;
                    end
                end
                M1_GNT: begin
                    if (!m1_req) begin
                        r_state    <= M0_GNT;
                        r_m0_grant <= 1'b1;
                        r_m1_grant <= 1'b0;
                    end else begin
                        r_state    <= M1_GNT;
                        r_m0_grant <= 1'b0;
                        r_m1_grant <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= M0_GNT;
                    r_m0_grant <= 1'b1;
                    r_m1_grant <= 1'b0;
                end
            endcase
        end
    end

    assign m0_grant = r_m0_grant;
    assign m1_grant = r_m1_grant;

    // Master mux: the owner drives the bus whether or not it is currently requesting.
    always_comb begin
        s_addr = m0_addr;
        s_wr   = m0_wr;
        s_din  = m0_dout;
        if (r_state == M1_GNT) begin
            s_addr = m1_addr;
            s_wr   = m1_wr;
            s_din  = m1_dout;
        end else begin
            s_addr = m0_addr;
            s_wr   = m0_wr;
            s_din  = m0_dout;
        end
    end

    // Decoder: s0/s1 are 32-byte windows, s2..s4 are 64-byte windows.
    always_comb begin
        w_sel    = 5'b00000;
        w_sel[0] = (s_addr[15:5] == 11'h000);
        w_sel[1] = (s_addr[15:5] == 11'h008);
        w_sel[2] = (s_addr[15:6] == 10'h008);
        w_sel[3] = (s_addr[15:6] == 10'h00C);
        w_sel[4] = (s_addr[15:6] == 10'h010);
    end

    assign s0_sel = w_sel[0];
    assign s1_sel = w_sel[1];
    assign s2_sel = w_sel[2];
    assign s3_sel = w_sel[3];
    assign s4_sel = w_sel[4];

`ifdef BUS_RD_PIPE_EN
    logic [4:0] r_sel;

    // Read select delayed one cycle to line up with synchronous-read slaves.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_sel <= 5'b00000;
        end else begin
            r_sel <= w_sel;
        end
    end

    assign w_rd_sel = r_sel;
`else
    assign w_rd_sel = w_sel;
`endif

    // Read mux: zero when nothing is selected; not gated by s_wr.
    always_comb begin
        m_din = {DATA_W{1'b0}};
        case (w_rd_sel)
            5'b00001: m_din = s0_dout;
            5'b00010: m_din = s1_dout;
            5'b00100: m_din = s2_dout;
            5'b01000: m_din = s3_dout;
            5'b10000: m_din = s4_dout;
            default:  m_din = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_bus_2m5s.sv
// Directed bench for bus_2m5s; read checks wait one cycle when BUS_RD_PIPE_EN is defined.
module tb_bus_2m5s;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_dout, m1_dout;
    logic [31:0] s0_dout, s1_dout, s2_dout, s3_dout, s4_dout;
    logic        m0_grant, m1_grant;
    logic [31:0] m_din;
    logic        s0_sel, s1_sel, s2_sel, s3_sel, s4_sel;
    logic [15:0] s_addr;
    logic        s_wr;
    logic [31:0] s_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_2m5s dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout),
        .s3_dout(s3_dout), .s4_dout(s4_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s2_sel(s2_sel),
        .s3_sel(s3_sel), .s4_sel(s4_sel),
        .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Read data check: combinational build sees it now, pipelined build one edge later.
    task automatic chk_rd(input string tag, input logic [31:0] exp);
`ifdef BUS_RD_PIPE_EN
        tick();
`else
        settle();
`endif
        chk(tag, m_din, exp);
    endtask

    function automatic logic [4:0] sels();
        return {s4_sel, s3_sel, s2_sel, s1_sel, s0_sel};
    endfunction

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0000; m0_dout = 32'h0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0000; m1_dout = 32'h0;
        s0_dout = 32'h0; s1_dout = 32'h0; s2_dout = 32'h0; s3_dout = 32'h0; s4_dout = 32'h0;

        // 1: reset
        tick();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        chk("rst_m0_grant", {31'h0, m0_grant}, 32'h1);
        chk("rst_m1_grant", {31'h0, m1_grant}, 32'h0);
        chk("rst_sel", {27'h0, sels()}, 32'h1);
        chk("rst_s_wr", {31'h0, s_wr}, 32'h0);
        chk("rst_m_din", m_din, 32'h0);

        // 2: m0 read/write s0
        s0_dout = 32'h0000_0001; m0_req = 1'b1;
        settle();
        chk("m0_s0_sel", {27'h0, sels()}, 32'h1);
        chk_rd("m0_s0_rd", 32'h0000_0001);
        m0_wr = 1'b1; m0_dout = 32'h0000_0020;
        settle();
        chk("m0_s0_wr", {31'h0, s_wr}, 32'h1);
        chk("m0_s0_din", s_din, 32'h0000_0020);

        // 3: hand over to m1, read/write s1
        m0_req = 1'b0; m1_req = 1'b1;
        m1_addr = 16'h0100; m1_wr = 1'b0; m1_dout = 32'h0000_4000; s1_dout = 32'h0000_0300;
        settle();
        chk("m1_grant_not_yet", {31'h0, m1_grant}, 32'h0);
        chk("owner_m0_idle_addr", {16'h0, s_addr}, 32'h0000);
        tick();
        chk("m1_grant", {30'h0, m1_grant, m0_grant}, 32'h2);
        chk("m1_s1_sel", {27'h0, sels()}, 32'h2);
        chk_rd("m1_s1_rd", 32'h0000_0300);
        m1_wr = 1'b1;
        settle();
        chk("m1_s1_wr", {31'h0, s_wr}, 32'h1);
        chk("m1_s1_din", s_din, 32'h0000_4000);
        chk("m1_s1_addr", {16'h0, s_addr}, 32'h0100);

        // 4: back to m0 at s2, then m1 at s3
        m1_req = 1'b0; m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0200; s2_dout = 32'h0005_0000;
        tick();
        chk("m0_regrant", {30'h0, m1_grant, m0_grant}, 32'h1);
        chk("m0_s2_sel", {27'h0, sels()}, 32'h4);
        chk_rd("m0_s2_rd", 32'h0005_0000);
        m0_wr = 1'b1; m0_dout = 32'h0060_0000;
        settle();
        chk("m0_s2_din", s_din, 32'h0060_0000);
        m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0300; s3_dout = 32'h0700_0000;
        tick();
        chk("m1_grant2", {30'h0, m1_grant, m0_grant}, 32'h2);
        chk("m1_s3_sel", {27'h0, sels()}, 32'h8);
        chk_rd("m1_s3_rd", 32'h0700_0000);
        m1_wr = 1'b1; m1_dout = 32'h8000_0000;
        settle();
        chk("m1_s3_din", s_din, 32'h8000_0000);
        m0_req = 1'b1;
        tick();
        chk("both_req_m1_keeps", {30'h0, m1_grant, m0_grant}, 32'h2);

        // 5: m0 at s4 and decode boundaries
        m1_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0400; s4_dout = 32'h0000_0011;
        tick();
        chk("m0_grant3", {30'h0, m1_grant, m0_grant}, 32'h1);
        chk("m0_s4_sel", {27'h0, sels()}, 32'h10);
        chk_rd("m0_s4_rd", 32'h0000_0011);
        m0_wr = 1'b1; m0_dout = 32'h0000_2200;
        settle();
        chk("m0_s4_din", s_din, 32'h0000_2200);
        chk_rd("rd_not_gated_by_wr", 32'h0000_0011);
        m0_wr = 1'b0;
        m0_addr = 16'h043F; settle(); chk("sel_043f", {27'h0, sels()}, 32'h10);
        m0_addr = 16'h0440; settle(); chk("sel_0440", {27'h0, sels()}, 32'h0);
        m0_addr = 16'h001F; settle(); chk("sel_001f", {27'h0, sels()}, 32'h1);
        m0_addr = 16'h011F; settle(); chk("sel_011f", {27'h0, sels()}, 32'h2);
        m0_addr = 16'h0120; settle(); chk("sel_0120", {27'h0, sels()}, 32'h0);
        m0_addr = 16'h023F; settle(); chk("sel_023f", {27'h0, sels()}, 32'h4);
        m0_addr = 16'h0500; settle(); chk("sel_0500", {27'h0, sels()}, 32'h0);
        m0_addr = 16'h0020; settle(); chk("sel_0020", {27'h0, sels()}, 32'h0);
        chk_rd("unmapped_rd", 32'h0);

        // 6: no preemption of m0, reset while m1 owns the bus
        m1_req = 1'b1;
        tick();
        chk("both_req_m0_keeps", {30'h0, m1_grant, m0_grant}, 32'h1);
        m0_req = 1'b0;
        tick();
        chk("m1_takes", {30'h0, m1_grant, m0_grant}, 32'h2);
        reset_n = 1'b1;
        tick();
        chk("rst_mid_m1", {30'h0, m1_grant, m0_grant}, 32'h1);
        reset_n = 1'b0;
        tick();
        chk("m1_after_rst", {30'h0, m1_grant, m0_grant}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_2m5s.md
Name: bus_2m5s

Overview:
- Shared-bus interconnect with 2 masters (m0, m1) and 5 memory-mapped slaves (s0..s4); sits between the DMA/CPU masters and the ALU/memory slaves.
- A registered 2-state arbiter grants exactly one master. The granted master's address, write enable and write data are forwarded to all slaves.
- An address decoder raises one slave select; the selected slave's read data is returned on m_din.

Parameters:
- ADDR_W, 16, address width (fixed; other values unsupported)
- DATA_W, 32, data width (fixed; other values unsupported)

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  synchronous reset, active-high (port keeps codebase name; reset when 1 at clk rise)
- m0_req  in  1  master 0 bus request
- m0_wr  in  1  master 0 write enable (1=write, 0=read)
- m0_addr  in  16  master 0 address
- m0_dout  in  32  master 0 write data
- m1_req  in  1  master 1 bus request
- m1_wr  in  1  master 1 write enable
- m1_addr  in  16  master 1 address
- m1_dout  in  32  master 1 write data
- s0_dout..s4_dout  in  32 each  slave read data (five ports, in order s0..s4)
- m0_grant  out  1  master 0 owns bus
- m1_grant  out  1  master 1 owns bus
- m_din  out  32  read data returned to masters
- s0_sel..s4_sel  out  1 each  slave selects (five ports, in order s0..s4)
- s_addr  out  16  address to slaves
- s_wr  out  1  write enable to slaves
- s_din  out  32  write data to slaves
- Positional port order: clk, reset_n, m0_req, m0_wr, m0_addr, m0_dout, m1_req, m1_wr, m1_addr, m1_dout, s0_dout..s4_dout, m0_grant, m1_grant, m_din, s0_sel..s4_sel, s_addr, s_wr, s_din.

Behaviour:
- Arbiter FSM, states M0_GNT and M1_GNT; grants are registered and one-hot (never both 1, never both 0).
- Reset: state M0_GNT (m0_grant=1, m1_grant=0). Reset overrides any request and takes effect at the next clk edge, even mid-transfer.
- M0_GNT -> M1_GNT only when m0_req=0 and m1_req=1; otherwise stay. If m0_req=1, m0 keeps the bus regardless of m1_req (no preemption).
- M1_GNT -> M0_GNT when m1_req=0, regardless of m0_req; stay while m1_req=1.
- Simultaneous m0_req=1 and m1_req=1 leaves the current owner unchanged. Grant changes take 1 cycle after the request edge.
- Master mux (combinational on grant):
  - s_addr, s_wr, s_din = granted master's addr, wr and dout.
  - The owner's signals are forwarded even when its req=0 (default owner m0).
- Decoder (combinational on s_addr):
  - s0: 0x0000-0x001F
  - s1: 0x0100-0x011F
  - s2: 0x0200-0x023F
  - s3: 0x0300-0x033F
  - s4: 0x0400-0x043F
  - At most one sel high. An unmapped address gives all sel=0.
  - Sel is asserted for both reads and writes; slaves qualify writes with s_wr.
- Read mux: m_din = dout of the selected slave; 32'h0 when no slave is selected. s_wr does not gate m_din.
- Outputs after reset: m0_grant=1, m1_grant=0, s_* follow m0 inputs, sel and m_din per decode of m0_addr.

Optional Feature:
- Macro BUS_RD_PIPE_EN.
- Defined:
  - The slave-select vector is registered (reset to all 0); m_din is muxed from the registered select.
  - Read data appears 1 cycle after the address is presented (matches synchronous-read slaves).
  - m_din = 0 for the cycle after reset.
- Undefined: m_din is a purely combinational mux of the current decode (0-cycle latency).
- Sel outputs, arbiter and write path are identical in both builds.

Test Plan:
1. Reset for 1 cycle with all inputs 0 -> m0_grant=1, m1_grant=0, s0_sel=1 (addr 0x0000), s_wr=0.
2. s0_dout=0x00000001, m0_req=1, m0_wr=0, m0_addr=0x0000 -> s0_sel=1, m_din=0x00000001 (next cycle if BUS_RD_PIPE_EN). Then m0_wr=1, m0_dout=0x00000020 -> s_wr=1, s_din=0x00000020.
3. m0_req=0, m1_req=1 -> m1_grant=1 one cycle later. m1 reads 0x0100 with s1_dout=0x00000300 -> s1_sel=1, m_din=0x00000300. m1 writes 0x00004000 -> s_din=0x00004000.
4. m1_req=0, m0_req=1 -> m0_grant restored. Read 0x0200 (s2_dout=0x00050000) -> m_din=0x00050000. Write 0x00600000. Repeat with m1 at 0x0300 (s3_dout=0x07000000, write 0x80000000).
5. m0 at 0x0400, s4_dout=0x00000011 -> s4_sel=1, m_din=0x00000011. Write 0x00002200 -> s_din=0x00002200. Address 0x0020 or 0x0500 -> all sel=0, m_din=0.
6. Both reqs high while m0 owns the bus -> m0 keeps grant. Assert reset while m1 owns the bus -> m0_grant=1 at next edge.
